// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem request per accepted PC,
// returned words queued with their fetch address for decode; flush drops everything.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  addr_valid,
    output logic                  addr_ready,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  flush,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q   [FIFO_DEPTH];

    logic accept;
    logic push;
    logic pop;

    assign addr_ready  = !reset && (state == IDLE) && !flush && (count < DEPTH_C);
    assign accept      = addr_valid && addr_ready;
    assign push        = (state == WAIT) && imem_ack && !flush;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !flush;

    // Head is gated so the outputs read zero whenever the buffer is empty.
    assign instr    = instr_valid ? data_q[rd_ptr] : '0;
    assign instr_pc = instr_valid ? pc_q[rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        imem_addr <= fetch_addr;
                        imem_req  <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack coincident with flush retires the request but its data is dropped.
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end else if (flush) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase

            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= imem_addr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs driven after the falling edge,
// outputs checked 1ns later, well clear of the rising edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_addr;
    logic        addr_valid;
    logic        addr_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_addr (fetch_addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Accept one address, then ack it on the first request cycle.
    task automatic fetch0(input logic [31:0] a, input logic [31:0] d);
        cyc(); addr_valid = 1'b1; fetch_addr = a; imem_ack = 1'b0;
        #1 chk("fetch0_ready", addr_ready, 1);
        cyc(); addr_valid = 1'b0; imem_ack = 1'b1; imem_rdata = d;
        #1 chk("fetch0_req", imem_req, 1);
        cyc(); imem_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_addr = '0; addr_valid = 1'b1; imem_ack = 1'b0;
        imem_rdata = '0; flush = 1'b0; instr_ready = 1'b0;

        // Reset state
        cyc(); cyc();
        #1;
        chk("rst_addr_ready", addr_ready, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);

        // 1: zero-wait fetch of 0x0 and 0x1
        cyc(); reset = 1'b0; addr_valid = 1'b1; fetch_addr = 32'h0; instr_ready = 1'b1;
        #1 chk("t1_ready0", addr_ready, 1);
        cyc(); fetch_addr = 32'h1; imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
        #1 chk("t1_req0", imem_req, 1); chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_busy", addr_ready, 0); chk("t1_nv0", instr_valid, 0);
        cyc(); imem_ack = 1'b0;
        #1 chk("t1_v0", instr_valid, 1); chk("t1_i0", instr, 32'h1111_0000);
        chk("t1_pc0", instr_pc, 32'h0); chk("t1_req_lo", imem_req, 0);
        chk("t1_ready1", addr_ready, 1);
        cyc(); addr_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1111_0001;
        #1 chk("t1_nv1", instr_valid, 0); chk("t1_addr1", imem_addr, 32'h1);
        cyc(); imem_ack = 1'b0;
        #1 chk("t1_v1", instr_valid, 1); chk("t1_i1", instr, 32'h1111_0001);
        chk("t1_pc1", instr_pc, 32'h1);
        cyc();
        #1 chk("t1_empty", instr_valid, 0);

        // 2: back-pressure, FIFO full blocks 0x12
        instr_ready = 1'b0;
        fetch0(32'h10, 32'hD000_0010);
        fetch0(32'h11, 32'hD000_0011);
        addr_valid = 1'b1; fetch_addr = 32'h12;
        #1 chk("t2_full_ready", addr_ready, 0); chk("t2_head10", instr_pc, 32'h10);
        cyc(); instr_ready = 1'b1;
        #1 chk("t2_not_acc", imem_req, 0); chk("t2_full_ready2", addr_ready, 0);
        chk("t2_i10", instr, 32'hD000_0010);
        cyc(); instr_ready = 1'b0;
        #1 chk("t2_head11", instr_pc, 32'h11); chk("t2_ready_after_pop", addr_ready, 1);
        cyc(); addr_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hD000_0012;
        #1 chk("t2_addr12", imem_addr, 32'h12); chk("t2_req12", imem_req, 1);
        cyc(); imem_ack = 1'b0; instr_ready = 1'b1;
        #1 chk("t2_pc11", instr_pc, 32'h11); chk("t2_i11", instr, 32'hD000_0011);
        cyc();
        #1 chk("t2_pc12", instr_pc, 32'h12); chk("t2_i12", instr, 32'hD000_0012);
        cyc();
        #1 chk("t2_empty", instr_valid, 0);

        // 3: multi-cycle memory
        cyc(); addr_valid = 1'b1; fetch_addr = 32'h20;
        for (int k = 0; k < 3; k++) begin
            cyc(); addr_valid = 1'b0; fetch_addr = 32'h99;
            if (k == 2) begin imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
            #1 chk("t3_req", imem_req, 1); chk("t3_addr", imem_addr, 32'h20);
            chk("t3_nv", instr_valid, 0);
        end
        cyc(); imem_ack = 1'b0;
        #1 chk("t3_v", instr_valid, 1); chk("t3_i", instr, 32'hDEAD_BEEF);
        chk("t3_pc", instr_pc, 32'h20);
        cyc();
        #1 chk("t3_empty", instr_valid, 0);

        // 4: flush in WAIT, late ack dropped
        cyc(); addr_valid = 1'b1; fetch_addr = 32'h30;
        cyc(); addr_valid = 1'b0;
        #1 chk("t4_req", imem_req, 1); chk("t4_addr", imem_addr, 32'h30);
        cyc(); flush = 1'b1;
        #1 chk("t4_flush_ready", addr_ready, 0);
        cyc(); flush = 1'b0; addr_valid = 1'b1; fetch_addr = 32'h40;
        #1 chk("t4_drop_ready", addr_ready, 0); chk("t4_drop_req", imem_req, 1);
        cyc(); imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        #1 chk("t4_drop_ready2", addr_ready, 0); chk("t4_drop_req2", imem_req, 1);
        cyc(); imem_ack = 1'b0;
        #1 chk("t4_no_data", instr_valid, 0); chk("t4_req_lo", imem_req, 0);
        chk("t4_ready", addr_ready, 1);
        cyc(); addr_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h4040_4040;
        #1 chk("t4_addr40", imem_addr, 32'h40); chk("t4_nv", instr_valid, 0);
        cyc(); imem_ack = 1'b0;
        #1 chk("t4_v", instr_valid, 1); chk("t4_i", instr, 32'h4040_4040);
        chk("t4_pc", instr_pc, 32'h40);
        cyc();
        #1 chk("t4_empty", instr_valid, 0);

        // 5a: flush a full FIFO, concurrent pop cancelled
        instr_ready = 1'b0;
        fetch0(32'h50, 32'h5050_5050);
        fetch0(32'h51, 32'h5151_5151);
        #1 chk("t5_full_ready", addr_ready, 0); chk("t5_full_v", instr_valid, 1);
        flush = 1'b1; instr_ready = 1'b1;
        cyc(); flush = 1'b0;
        #1 chk("t5_flushed_v", instr_valid, 0); chk("t5_flushed_ready", addr_ready, 1);
        chk("t5_flushed_pc", instr_pc, 0);

        // 5b: flush coincident with ack discards data
        instr_ready = 1'b0;
        fetch0(32'h60, 32'h6060_6060);
        addr_valid = 1'b1; fetch_addr = 32'h61;
        cyc(); addr_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00; flush = 1'b1;
        #1 chk("t5b_req", imem_req, 1); chk("t5b_head", instr_pc, 32'h60);
        cyc(); imem_ack = 1'b0; flush = 1'b0;
        #1 chk("t5b_req_lo", imem_req, 0); chk("t5b_v", instr_valid, 0);
        chk("t5b_ready", addr_ready, 1);
        cyc();
        #1 chk("t5b_v2", instr_valid, 0);

        // 6: reset mid-WAIT, stale ack ignored
        instr_ready = 1'b1;
        cyc(); addr_valid = 1'b1; fetch_addr = 32'h70;
        cyc(); addr_valid = 1'b0;
        #1 chk("t6_req", imem_req, 1);
        cyc(); reset = 1'b1;
        #1 chk("t6_rst_ready", addr_ready, 0);
        cyc(); reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        #1 chk("t6_req_lo", imem_req, 0); chk("t6_v", instr_valid, 0);
        chk("t6_addr", imem_addr, 0);
        cyc(); imem_ack = 1'b0;
        #1 chk("t6_stale", instr_valid, 0); chk("t6_req_lo2", imem_req, 0);
        chk("t6_ready", addr_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the word address produced by the PC and issues a single-outstanding request to instruction memory over a req/ack handshake.
- Buffers returned instructions with their fetch address in a small FIFO.
- Presents instructions to decode over a valid/ready handshake. A flush input discards buffered and in-flight fetches when a branch or jump redirects the PC.

Parameters:
- ADDR_WIDTH, 32, width of the word address (the PC increments by 1 per instruction).
- DATA_WIDTH, 32, instruction width.
- FIFO_DEPTH, 2, output buffer entries; legal values 2..8, power of two.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_addr  in  ADDR_WIDTH  word address from the program counter.
- addr_valid  in  1  fetch_addr is valid this cycle.
- addr_ready  out  1  address accepted when addr_valid && addr_ready.
- imem_req  out  1  request to instruction memory; held until ack.
- imem_addr  out  ADDR_WIDTH  request address; stable while imem_req=1.
- imem_ack  in  1  memory response valid; only meaningful while imem_req=1.
- imem_rdata  in  DATA_WIDTH  instruction word, valid with imem_ack.
- flush  in  1  discard all buffered and in-flight fetches.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decode consumes head when instr_valid && instr_ready.
- instr  out  DATA_WIDTH  FIFO head instruction.
- instr_pc  out  ADDR_WIDTH  fetch address of FIFO head.

Behaviour:
- Reset:
  - state=IDLE, FIFO empty (count=0, pointers 0).
  - imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0.
  - addr_ready=0 during reset.
  - Reset mid-transaction abandons it: imem_req drops the next cycle and a late ack is ignored (state IDLE).
- States: IDLE, WAIT, DROP.
- addr_ready = (state==IDLE) && !flush && (count < FIFO_DEPTH). Combinational; no dependency on addr_valid.
- IDLE:
  - On accept, latch fetch_addr into imem_addr and set imem_req=1 next cycle.
  - Go to WAIT.
- WAIT:
  - imem_req=1 and imem_addr held constant.
  - On imem_ack && !flush: push {imem_addr, imem_rdata}, clear imem_req next cycle, go to IDLE.
  - On flush (with or without ack): go to DROP if no ack this cycle. If ack arrives in the same cycle as flush, discard the data and go to IDLE.
- DROP:
  - imem_req stays 1 until imem_ack; the data is discarded, not pushed.
  - Then imem_req=0 and go to IDLE. No new address is accepted while in DROP.
- Latency: address accepted in cycle N, imem_req=1 in N+1. With ack in cycle M ≥ N+1, instr_valid=1 in M+1.
- Throughput: with zero-wait memory (ack in the first req cycle), one instruction per 2 cycles. Only one request is outstanding at a time.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Pop when empty is ignored.
  - A push is never attempted when full, because addr_ready gates on count.
  - Pointers wrap modulo FIFO_DEPTH.
  - instr and instr_pc are driven from the registered head entry.
- Flush:
  - FIFO is emptied at the next edge (count=0, instr_valid=0 the next cycle).
  - Any pop or push in the flush cycle is cancelled.
  - addr_ready=0 during the flush cycle.
- Address arithmetic: none. instr_pc equals the accepted fetch_addr exactly, with no offset.

Test Plan:
1. Reset then zero-wait fetch. Drive addr 0x00000000 then 0x00000001; ack in the first req cycle; instr_ready=1. Required: imem_addr 0x0 then 0x1; instr/instr_pc pairs delivered in order; one instr_valid pulse every 2 cycles.
2. Back-pressure. Hold instr_ready=0 while fetching addrs 0x10, 0x11, 0x12. Required: 0x10 and 0x11 are buffered; addr_ready=0 with count=2 and 0x12 is not accepted. After one pop, 0x12 is fetched; output order is 0x10, 0x11, 0x12.
3. Multi-cycle memory. Ack 3 cycles after req for addr 0x20, data 0xDEADBEEF. Required: imem_req high and imem_addr=0x20 stable for all 3 cycles; instr=0xDEADBEEF, instr_pc=0x20 one cycle after ack.
4. Flush in WAIT. Assert flush 1 cycle after req for 0x30; ack 2 cycles later with 0xAAAA5555. Required: DROP entered; data is never presented; addr_ready stays 0 until the ack; next address 0x40 fetches normally.
5. Flush with a full FIFO plus flush coincident with ack. Required: instr_valid=0 the next cycle, count=0, and the coincident ack data is discarded.
6. Reset mid-WAIT. Then ack arrives. Required: imem_req=0 after reset and no instr_valid from the stale ack.
